wb_conbus_rr_sched: RTL and testbench

//   Round-robin bus-ownership scheduler for the wb_conbus shared master->slave bus.

---
 rtl/wb_conbus_rr_sched_if.sv | 37 +++
 rtl/wb_conbus_rr_sched.sv | 142 ++++++++++++++
 tb/tb_wb_conbus_rr_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_conbus_rr_sched_if.sv
// wb_conbus round-robin scheduler bus bundle.
// Requests and status in, grant and watchdog status out.
interface wb_conbus_rr_sched_if #(
  parameter int M_NUM = 8,
  parameter int GNT_W = 3
);
  logic [M_NUM-1:0] req;
  logic             stb_s;
  logic             term;
  logic [GNT_W-1:0] gnt;
  logic             gnt_vld;
  logic [M_NUM-1:0] gnt_oh;
  logic             to_err;
  logic [7:0]       to_cnt;

  modport slave (
    input  req,
    input  stb_s,
    input  term,
    output gnt,
    output gnt_vld,
    output gnt_oh,
    output to_err,
    output to_cnt
  );

  modport master (
    output req,
    output stb_s,
    output term,
    input  gnt,
    input  gnt_vld,
    input  gnt_oh,
    input  to_err,
    input  to_cnt
  );
endinterface

// File: rtl/wb_conbus_rr_sched.sv
// wb_conbus round-robin bus-ownership scheduler.
// Grants hold for a whole cycle; a watchdog aborts stalled cycles.
module wb_conbus_rr_sched #(
  parameter int M_NUM   = 8,
  parameter int GNT_W   = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  wb_conbus_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    ABORT
  } state_t;

  localparam int SW = GNT_W + 1;
  localparam logic [TO_W-1:0] WD_LAST =
    TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, state_n;
  logic [GNT_W-1:0] gnt_q, gnt_n;
  logic [GNT_W-1:0] ptr, ptr_n;
  logic [TO_W-1:0]  wd, wd_n;
  logic             err_q, err_n;
  logic [7:0]       cnt_q, cnt_n;

  logic [GNT_W-1:0] win;
  logic             any;
  logic [SW-1:0]    idx;
  logic             own_req;
  logic             stall;
  logic             fire;
  logic             rearb;
  logic             take;
  logic             vld;
  logic [M_NUM-1:0] oh;

  // rotating priority search starting just after the last winner
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = M_NUM; i >= 1; i--) begin
      idx = {1'b0, ptr} + SW'(i);
      if (idx >= SW'(M_NUM))
        idx = idx - SW'(M_NUM);
      if (bus.req[idx[GNT_W-1:0]]) begin
        win = idx[GNT_W-1:0];
        any = 1'b1;
      end
    end
  end

  assign own_req = bus.req[gnt_q];
  assign stall   = bus.stb_s & ~bus.term;
  assign fire    = (TIMEOUT != 0) && stall
                 && (wd == WD_LAST);

  // next state, grant hand-over and watchdog bookkeeping
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    ptr_n   = ptr;
    wd_n    = '0;
    err_n   = 1'b0;
    cnt_n   = cnt_q;
    rearb   = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = OWN;
          take    = 1'b1;
        end
      end
      OWN: begin
        if (fire) begin
          state_n = ABORT;
          err_n   = 1'b1;
          if (cnt_q != 8'hFF)
            cnt_n = cnt_q + 8'd1;
        end else if (!own_req) begin
          rearb = 1'b1;
        end else if (stall) begin
          wd_n = wd + TO_W'(1);
        end
      end
      ABORT: begin
        if (!own_req)
          rearb = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (rearb) begin
      state_n = any ? OWN : IDLE;
      take    = any;
    end
    if (take) begin
      gnt_n = win;
      ptr_n = win;
    end
  end

  // state and counters, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt_q <= '0;
      ptr   <= GNT_W'(M_NUM - 1);
      wd    <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      ptr   <= ptr_n;
      wd    <= wd_n;
      err_q <= err_n;
      cnt_q <= cnt_n;
    end
  end

  assign vld = (state != IDLE);

  // one-hot grant, zero while nobody owns the bus
  always_comb begin
    oh = '0;
    if (vld)
      oh[gnt_q] = 1'b1;
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld;
  assign bus.gnt_oh  = oh;
  assign bus.to_err  = err_q;
  assign bus.to_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_conbus_rr_sched.sv
// Bench for wb_conbus_rr_sched: directed cases plus random traffic
// checked cycle by cycle against a queue-fed reference model.
module tb_wb_conbus_rr_sched;

  localparam int M  = 8;
  localparam int TO = 4;

  typedef struct {
    logic       vld;
    logic [2:0] gnt;
    logic [7:0] oh;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_conbus_rr_sched_if #(.M_NUM(M), .GNT_W(3)) bus ();

  wb_conbus_rr_sched #(
    .M_NUM  (M),
    .GNT_W  (3),
    .TO_W   (8),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int m_owner;
  int m_last;
  int m_gnt;
  bit m_abt;
  int m_stall;
  int m_cnt;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  function automatic bit has(input logic [7:0] r, input int b);
    return ((r >> b) & 8'h01) != 8'h00;
  endfunction

  function automatic int next_rr(input logic [7:0] r, input int last);
    for (int k = 1; k <= M; k++)
      if (has(r, (last + k) % M))
        return (last + k) % M;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = M - 1;
    m_gnt   = 0;
    m_abt   = 0;
    m_stall = 0;
    m_cnt   = 0;
  endtask

  task automatic grant(input logic [7:0] r);
    m_owner = next_rr(r, m_last);
    m_last  = m_owner;
    m_gnt   = m_owner;
    m_stall = 0;
    m_abt   = 0;
  endtask

  // one clock of the abstract ownership model
  task automatic model_step(input logic [7:0] r,
                            input logic s, input logic t);
    exp_t e;
    bit err;
    err = 0;
    if (m_owner < 0) begin
      if (r != 8'h00) grant(r);
    end else if (!m_abt && s && !t && m_stall + 1 == TO) begin
      m_abt   = 1;
      err     = 1;
      m_stall = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (!has(r, m_owner)) begin
      m_abt   = 0;
      m_stall = 0;
      if (r != 8'h00) grant(r);
      else m_owner = -1;
    end else if (!m_abt) begin
      m_stall = (s && !t) ? m_stall + 1 : 0;
    end
    e.vld = (m_owner >= 0);
    e.gnt = 3'(m_gnt);
    e.oh  = e.vld ? (8'h01 << m_gnt) : 8'h00;
    e.err = err;
    e.cnt = 8'(m_cnt);
    q.push_back(e);
  endtask

  task automatic cyc(input logic [7:0] r,
                     input logic s, input logic t);
    bus.req   = r;
    bus.stb_s = s;
    bus.term  = t;
    @(posedge clk);
    model_step(r, s, t);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_oh", 32'(bus.gnt_oh), 32'd0);
    chk("rst_err", 32'(bus.to_err), 32'd0);
    chk("rst_cnt", 32'(bus.to_cnt), 32'd0);
    model_reset();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: compare every registered output against the model
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && q.size() > 0) begin
        e = q.pop_front();
        chk("gnt_vld", 32'(bus.gnt_vld), 32'(e.vld));
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("gnt_oh", 32'(bus.gnt_oh), 32'(e.oh));
        chk("to_err", 32'(bus.to_err), 32'(e.err));
        chk("to_cnt", 32'(bus.to_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] mask;
    int pulses;
    int at;

    bus.req   = '0;
    bus.stb_s = 1'b0;
    bus.term  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_gnt", 32'(bus.gnt), 32'd0);
    chk("init_vld", 32'(bus.gnt_vld), 32'd0);
    chk("init_oh", 32'(bus.gnt_oh), 32'd0);
    chk("init_cnt", 32'(bus.to_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single request from reset
    cyc(8'h01, 1'b0, 1'b0);
    chk("t1_oh", 32'(bus.gnt_oh), 32'h01);
    cyc(8'h00, 1'b0, 1'b0);

    // no pre-emption mid-cycle
    cyc(8'h04, 1'b0, 1'b0);
    repeat (3) cyc(8'h24, 1'b0, 1'b0);
    chk("t3_hold", 32'(bus.gnt), 32'd2);
    cyc(8'h20, 1'b0, 1'b0);
    chk("t3_next", 32'(bus.gnt), 32'd5);
    cyc(8'h00, 1'b0, 1'b0);

    // watchdog abort
    cyc(8'h01, 1'b0, 1'b0);
    pulses = 0;
    at = -1;
    for (int i = 0; i < 7; i++) begin
      cyc(8'h01, 1'b1, 1'b0);
      if (bus.to_err) begin
        pulses++;
        at = i;
      end
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_at", 32'(at), 32'd3);
    chk("t4_hold", 32'(bus.gnt_vld), 32'd1);
    chk("t4_cnt", 32'(bus.to_cnt), 32'd1);
    cyc(8'h00, 1'b0, 1'b0);

    // term in the firing cycle wins
    cyc(8'h02, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(8'h02, 1'b1, (i == 3) ? 1'b1 : 1'b0);
      if (bus.to_err) pulses++;
    end
    chk("t5_pulses", 32'(pulses), 32'd0);
    chk("t5_cnt", 32'(bus.to_cnt), 32'd1);
    cyc(8'h00, 1'b0, 1'b0);

    // full rotation, no idle gap
    async_reset();
    cyc(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc(8'hFF, 1'b0, 1'b0);
      cyc(8'hFF, 1'b0, 1'b0);
      cyc(8'hFF & ~(8'h01 << (k % M)), 1'b0, 1'b0);
      chk("t2_order", 32'(bus.gnt), 32'((k + 1) % M));
      chk("t2_gap", 32'(bus.gnt_vld), 32'd1);
    end
    cyc(8'h00, 1'b0, 1'b0);

    // async reset while master 6 owns
    cyc(8'h40, 1'b0, 1'b0);
    cyc(8'h40, 1'b0, 1'b0);
    chk("t6_own", 32'(bus.gnt), 32'd6);
    async_reset();
    cyc(8'hC0, 1'b0, 1'b0);
    chk("t6_after", 32'(bus.gnt), 32'd6);

    // random traffic
    r = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      mask = '0;
      for (int b = 0; b < M; b++)
        if ($urandom_range(7) == 0) mask[b] = 1'b1;
      r = r ^ mask;
      if (m_owner >= 0 && $urandom_range(5) == 0)
        r = r & ~(8'h01 << m_owner);
      cyc(r, ($urandom_range(3) != 0),
          ($urandom_range(5) == 0));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
